// File: rtl/addsub_calc_display.sv
// addsub_calc_display: W-bit two's-complement add/subtract with a registered
// (W+1)-bit exact result, a sequential double-dabble binary-to-BCD converter
// and a 4-digit active-low multiplexed seven-segment scanner.
module addsub_calc_display #(
  parameter int W       = 3,
  parameter int REFRESH = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W:0]   result,
  output logic         ov,
  output logic [6:0]   seg,
  output logic [3:0]   an
);

  localparam int            CW         = $clog2(REFRESH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH - 1);
  localparam logic [3:0]    SHIFT_LAST = 4'(W);
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]    SEG_MINUS  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2,
    LOAD = 2'd3
  } state_t;

  // Double-dabble nibble correction applied before each shift.
  function automatic logic [3:0] add3_ge5(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) r = n + 4'd3;
    else           r = n;
    return r;
  endfunction

  // Decimal digit to active-low {g,f,e,d,c,b,a} pattern; non-decimal is blank.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          sub_q, sub_d;
  logic [W:0]    result_q, result_d;
  logic          ov_q, ov_d;
  logic          sign_q, sign_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [W:0]    bin_q, bin_d;
  logic [3:0]    shift_q, shift_d;
  logic [3:0]    hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic          neg_q, neg_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          lit_q, lit_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic [W:0]    a_ext_s, b_ext_s, sum_s, mag_s;
  logic [11:0]   bcd_adj_s;
  logic          wrap_s;

  // Full-precision sum/difference of the captured operands and its magnitude.
  always_comb begin
    a_ext_s = {a_q[W-1], a_q};
    b_ext_s = {b_q[W-1], b_q};
    if (sub_q) sum_s = a_ext_s - b_ext_s;
    else       sum_s = a_ext_s + b_ext_s;
    // -2^W maps to 2^W, which is exact as a (W+1)-bit unsigned value.
    if (sum_s[W]) mag_s = (~sum_s) + {{W{1'b0}}, 1'b1};
    else          mag_s = sum_s;
  end

  // FSM next state, operand capture, result register, converter and display load.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    result_d  = result_q;
    ov_d      = ov_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    shift_d   = shift_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    neg_d     = neg_q;
    bcd_adj_s = {add3_ge5(bcd_q[11:8]), add3_ge5(bcd_q[7:4]), add3_ge5(bcd_q[3:0])};
    case (state_q)
      IDLE: begin
        if (go) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        result_d = sum_s;
        ov_d     = sum_s[W] ^ sum_s[W-1];
        sign_d   = sum_s[W];
        bin_d    = mag_s;
        bcd_d    = 12'd0;
        shift_d  = 4'd0;
        state_d  = CONV;
      end
      CONV: begin
        bcd_d   = {bcd_adj_s[10:0], bin_q[W]};
        bin_d   = {bin_q[W-1:0], 1'b0};
        shift_d = shift_q + 4'd1;
        if (shift_q == SHIFT_LAST) state_d = LOAD;
        else                       state_d = CONV;
      end
      LOAD: begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        neg_d   = sign_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == LOAD);
  end

  // Free-running digit scanner; patterns use the next display values so a LOAD
  // shows up on the edge that leaves LOAD.
  always_comb begin
    wrap_s = (cnt_q == CNT_LAST);
    if (wrap_s) begin
      cnt_d = '0;
      lit_d = 1'b1;
      if (lit_q) idx_d = idx_q + 2'd1;
      else       idx_d = 2'd0;
    end else begin
      cnt_d = cnt_q + CW'(1);
      lit_d = lit_q;
      idx_d = idx_q;
    end
    seg_d = SEG_BLANK;
    an_d  = 4'b1111;
    if (lit_d) begin
      case (idx_d)
        2'd0: begin
          an_d  = 4'b1110;
          seg_d = digit_seg(ones_d);
        end
        2'd1: begin
          an_d = 4'b1101;
          if (hund_d == 4'd0 && tens_d == 4'd0) seg_d = SEG_BLANK;
          else                                  seg_d = digit_seg(tens_d);
        end
        2'd2: begin
          an_d = 4'b1011;
          if (hund_d == 4'd0) seg_d = SEG_BLANK;
          else                seg_d = digit_seg(hund_d);
        end
        2'd3: begin
          an_d = 4'b0111;
          if (neg_d) seg_d = SEG_MINUS;
          else       seg_d = SEG_BLANK;
        end
        default: begin
          an_d  = 4'b1111;
          seg_d = SEG_BLANK;
        end
      endcase
    end else begin
      seg_d = SEG_BLANK;
      an_d  = 4'b1111;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      ov_q     <= 1'b0;
      sign_q   <= 1'b0;
      bcd_q    <= 12'd0;
      bin_q    <= '0;
      shift_q  <= 4'd0;
      hund_q   <= 4'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      lit_q    <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= 4'b1111;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      ov_q     <= ov_d;
      sign_q   <= sign_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      shift_q  <= shift_d;
      hund_q   <= hund_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lit_q    <= lit_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ov     = ov_q;
  assign seg    = seg_q;
  assign an     = an_q;

endmodule

// File: tb/tb_addsub_calc_display.sv
// Directed, table-driven bench for addsub_calc_display: one W=3/REFRESH=4
// instance and one W=9/REFRESH=2 instance share the stimulus.
module tb_addsub_calc_display;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;

  typedef struct {
    logic        wide;  // 0: W=3 instance, 1: W=9 instance
    logic        sub;
    int          a;
    int          b;
    int          res;
    logic        ovf;
    logic [27:0] segs;  // {sign, hundreds, tens, ones}
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic go_drv, sub_drv, sel_wide;
  int   a_drv, b_drv;

  logic       go3, busy3, done3, ov3;
  logic [2:0] a3, b3;
  logic [3:0] result3, an3;
  logic [6:0] seg3;

  logic       go9, busy9, done9, ov9;
  logic [8:0] a9, b9;
  logic [9:0] result9;
  logic [3:0] an9;
  logic [6:0] seg9;

  logic       cur_busy, cur_done, cur_ov;
  int         cur_res;
  logic [3:0] cur_an;
  logic [6:0] cur_seg;

  int tests = 0;
  int fails = 0;
  vec_t vecs[13];

  always #5 clk = ~clk;

  assign go3 = go_drv & ~sel_wide;
  assign go9 = go_drv & sel_wide;
  assign a3  = a_drv[2:0];
  assign b3  = b_drv[2:0];
  assign a9  = a_drv[8:0];
  assign b9  = b_drv[8:0];

  addsub_calc_display #(.W(3), .REFRESH(4)) dut3 (
    .clk(clk), .rst(rst), .go(go3), .sub(sub_drv), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .result(result3), .ov(ov3), .seg(seg3), .an(an3)
  );

  addsub_calc_display #(.W(9), .REFRESH(2)) dut9 (
    .clk(clk), .rst(rst), .go(go9), .sub(sub_drv), .a(a9), .b(b9),
    .busy(busy9), .done(done9), .result(result9), .ov(ov9), .seg(seg9), .an(an9)
  );

  // Route the observed instance's outputs to one set of names.
  always_comb begin
    cur_busy = sel_wide ? busy9 : busy3;
    cur_done = sel_wide ? done9 : done3;
    cur_ov   = sel_wide ? ov9 : ov3;
    cur_res  = sel_wide ? int'($signed(result9)) : int'($signed(result3));
    cur_an   = sel_wide ? an9 : an3;
    cur_seg  = sel_wide ? seg9 : seg3;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Wait (bounded) for anode p to be lit, then compare its segment pattern.
  task automatic chk_digit(input int p, input logic [6:0] exp_seg, input string nm);
    logic [3:0] tgt;
    bit found;
    found = 1'b0;
    tgt = ~(4'b0001 << p);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cur_an == tgt) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk({nm, " anode timeout"}, int'(cur_an), int'(tgt));
    else        chk(nm, int'(cur_seg), int'(exp_seg));
  endtask

  // Issue one operation from a negedge and check latency, result, ov, display.
  task automatic run_vec(input int i, input vec_t v);
    int dk;
    int wv;
    wv = v.wide ? 9 : 3;
    sel_wide = v.wide;
    a_drv = v.a;
    b_drv = v.b;
    sub_drv = v.sub;
    go_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go_drv = 1'b0;
    chk($sformatf("vec%0d busy after accept", i), int'(cur_busy), 1);
    dk = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("vec%0d result", i), cur_res, v.res);
        chk($sformatf("vec%0d ov", i), int'(cur_ov), int'(v.ovf));
      end
      if (cur_done) begin
        dk = k;
        break;
      end
    end
    chk($sformatf("vec%0d done latency", i), dk, wv + 2);
    @(negedge clk);
    chk($sformatf("vec%0d busy/done after LOAD", i), int'({cur_busy, cur_done}), 0);
    for (int p = 0; p < 4; p++)
      chk_digit(p, v.segs[p*7 +: 7], $sformatf("vec%0d digit%0d", i, p));
  endtask

  initial begin
    int dcount;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int idx;

    vecs[0]  = '{1'b0, 1'b0,    3,    2,    5, 1'b1, {BL, BL, BL, D5}};
    vecs[1]  = '{1'b0, 1'b0,   -4,   -4,   -8, 1'b1, {MI, BL, BL, D8}};
    vecs[2]  = '{1'b0, 1'b1,    1,    3,   -2, 1'b0, {MI, BL, BL, D2}};
    vecs[3]  = '{1'b0, 1'b1,    3,   -4,    7, 1'b1, {BL, BL, BL, D7}};
    vecs[4]  = '{1'b0, 1'b0,   -1,    1,    0, 1'b0, {BL, BL, BL, D0}};
    vecs[5]  = '{1'b0, 1'b0,    2,    1,    3, 1'b0, {BL, BL, BL, D3}};
    vecs[6]  = '{1'b0, 1'b1,   -4,    3,   -7, 1'b1, {MI, BL, BL, D7}};
    vecs[7]  = '{1'b1, 1'b1, -256,  255, -511, 1'b1, {MI, D5, D1, D1}};
    vecs[8]  = '{1'b1, 1'b0,  255,  255,  510, 1'b1, {BL, D5, D1, D0}};
    vecs[9]  = '{1'b1, 1'b1,  100,    0,  100, 1'b0, {BL, D1, D0, D0}};
    vecs[10] = '{1'b1, 1'b0,    5,    4,    9, 1'b0, {BL, BL, BL, D9}};
    vecs[11] = '{1'b1, 1'b0, -256, -256, -512, 1'b1, {MI, D5, D1, D2}};
    vecs[12] = '{1'b1, 1'b1,   20,    7,   13, 1'b0, {BL, BL, D1, D3}};

    rst = 1'b1; go_drv = 1'b0; sub_drv = 1'b0; a_drv = 0; b_drv = 0; sel_wide = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and the blank-then-scan sequence of the W=3 instance.
    chk("reset result", cur_res, 0);
    chk("reset ov", int'(cur_ov), 0);
    chk("reset busy", int'(cur_busy), 0);
    chk("reset result W9", int'(result9), 0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k < 4) begin
        exp_an = 4'b1111;
        exp_seg = BL;
      end else begin
        idx = ((k - 4) / 4) % 4;
        exp_an = ~(4'b0001 << idx);
        exp_seg = (idx == 0) ? D0 : BL;
      end
      chk($sformatf("reset scan an k=%0d", k), int'(cur_an), int'(exp_an));
      chk($sformatf("reset scan seg k=%0d", k), int'(cur_seg), int'(exp_seg));
    end

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // go pulsed during CONV with a different operand is ignored.
    sel_wide = 1'b0; a_drv = 1; b_drv = 3; sub_drv = 1'b1; go_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go_drv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    go_drv = 1'b1; a_drv = 0;
    @(negedge clk);
    go_drv = 1'b0; a_drv = 1;
    dcount = 0;
    if (cur_done) dcount++;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      if (cur_done) dcount++;
    end
    chk("go during CONV done count", dcount, 1);
    chk("go during CONV result", cur_res, -2);
    chk("go during CONV busy", int'(cur_busy), 0);

    // go held high: operations repeat; two dones inside a 15-cycle window.
    a_drv = 2; b_drv = 1; sub_drv = 1'b0; go_drv = 1'b1;
    dcount = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (cur_done) dcount++;
    end
    go_drv = 1'b0;
    chk("held go done count", dcount, 2);
    chk("held go result", cur_res, 3);
    for (int k = 0; k < 12; k++) @(negedge clk);

    // Known negative display, then reset during the second CONV cycle.
    run_vec(2, vecs[2]);
    a_drv = 3; b_drv = 2; sub_drv = 1'b0; go_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go_drv = 1'b0;
    @(negedge clk);
    chk("pre-reset result", cur_res, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-CONV reset busy", int'(cur_busy), 0);
    chk("mid-CONV reset result", cur_res, 0);
    chk("mid-CONV reset ov", int'(cur_ov), 0);
    dcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (cur_done) dcount++;
    end
    chk("mid-CONV reset done count", dcount, 0);
    chk_digit(0, D0, "mid-CONV reset ones");
    chk_digit(3, BL, "mid-CONV reset sign");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
